sprite_layer_mixer: RTL
=======================

SPRITE_LAYER_MIXER -- requirements
Module: sprite_layer_mixer

Interface
REQ-001 SHALL have parameter FLASH_FRAMES, default 8: frames of gem-pickup flash after a score increment.
REQ-002 SHALL have parameter FLASH_BOOST, default 8'h40: per-channel add applied during flash.
REQ-003 SHALL have parameter H_ACTIVE, default 640: visible width in pixels.
REQ-004 SHALL have parameter V_ACTIVE, default 480: visible height in pixels.
REQ-005 SHALL have port Clk, input, 1: the only clock.
REQ-006 SHALL have port Reset, input, 1: reset, synchronous to Clk, active-high.
REQ-007 SHALL have ports DrawX, DrawY, input, 10 each: current pixel coordinate, valid in cycle t.
REQ-008 SHALL have ports is_score, input, 1, and score_data, input, 8: score-digit layer hit and palette index, valid in cycle t.
REQ-009 SHALL have ports is_gem, input, 1, valid in cycle t, and gem_data, input, 8, valid in cycle t+1 (registered ROM output).
REQ-010 SHALL have ports is_player1 and is_player2, input, 1 each, and player1_data and player2_data, input, 8 each: player layers, valid in cycle t.
REQ-011 SHALL have port bg_data, input, 8: background palette index, valid in cycle t.
REQ-012 SHALL have port score_hex, input, 4: current score, 0..15.
REQ-013 SHALL have ports VGA_R, VGA_G, VGA_B, output, 8 each: final pixel colour.

Function
REQ-014 SHALL register DrawX, DrawY, all is_* flags, score_data, player data and bg_data once (stage 1), so that they align with gem_data.
REQ-015 SHALL pick one layer in stage 1, priority score > player1 > player2 > gem > background.
REQ-016 SHALL treat a sprite layer as transparent when its data equals 8'h00, passing selection to the next layer.
REQ-017 SHALL never treat the background as transparent.
REQ-018 SHALL look up the selected index in a 16-entry x 24-bit palette addressed by index[3:0], ignoring index[7:4].
REQ-019 SHALL fix palette entry 0 = 24'h000000 and entry 8 = 24'hFFFFFF; all other entries load from the team palette hex file.
REQ-020 SHALL register the palette result into VGA_R/G/B (stage 2), giving a fixed latency of 2 cycles from DrawX/DrawY to colour.
REQ-021 SHALL output 24'h000000 when the stage-1 coordinate has DrawX >= H_ACTIVE or DrawY >= V_ACTIVE, regardless of layers.
REQ-022 SHALL generate frame_start as a one-cycle pulse when stage-1 coordinates are (0,0) and the previous stage-1 coordinates were not (0,0), so that at most one pulse occurs per frame.
REQ-023 SHALL hold score_q, a registered copy of score_hex, updated every cycle.
REQ-024 SHALL implement FSM states IDLE and FLASH, with a frame counter flash_cnt of width clog2(FLASH_FRAMES+1).
REQ-025 SHALL, in IDLE, move to FLASH and load flash_cnt = FLASH_FRAMES when score_hex > score_q.
REQ-026 SHALL, in FLASH, decrement flash_cnt on frame_start and return to IDLE when flash_cnt is 1 at a frame_start.
REQ-027 SHALL, in FLASH, reload flash_cnt = FLASH_FRAMES when a further increment (score_hex > score_q) occurs; reload wins over a simultaneous frame_start.
REQ-028 SHALL, in any state, go to IDLE with no flash when score_hex < score_q.
REQ-029 SHALL, while in FLASH, make each non-blanked output channel min(channel + FLASH_BOOST, 8'hFF) (saturating); blanked pixels stay 0.
REQ-030 SHALL sample the FLASH state for boost in stage 2, in the same cycle the colour is registered.

Reset
REQ-031 SHALL, while Reset = 1 at a Clk edge, clear VGA_R/G/B to 0, all pipeline registers to 0, score_q to 0, flash_cnt to 0 and the FSM to IDLE.
REQ-032 SHALL, when Reset is asserted mid-FLASH, abort the flash so that the first post-reset increment starts a fresh FLASH_FRAMES count.
REQ-033 SHALL produce valid colour 2 cycles after Reset deasserts.

Verification
REQ-034 SHALL cover: is_score = 1, score_data = 8'h08, is_player1 = 1, at (100,50) -> 2 cycles later RGB = FFFFFF.
REQ-035 SHALL cover: is_gem = 1 at t, gem_data = 8'h00 at t+1, bg_data = 8'h00 -> RGB = 000000 (transparency falls through to background).
REQ-036 SHALL cover: DrawX = 700, is_score = 1, score_data = 8'h08 -> RGB = 000000.
REQ-037 SHALL cover: score_hex steps 0->1, bg index 8 -> RGB = FFFFFF; bg index 0 -> RGB = 404040 for exactly 8 frame_start pulses, then 000000.
REQ-038 SHALL cover: score_hex 1->2 at frame 5 of a flash -> flash lasts 8 more frames; score_hex 2->0 mid-flash -> immediate IDLE, no boost.
REQ-039 SHALL cover: Reset pulsed for 1 cycle mid-FLASH -> outputs 0, FSM IDLE, no boost on following frames.

Source files
------------

// File: rtl/sprite_layer_mixer.sv
`default_nettype none
// ============================================================================
// sprite_layer_mixer
// Priority mux of sprite layers, 16-entry palette, and a gem-pickup flash.
// The pipeline is two stages, so colour appears 2 cycles after DrawX/DrawY.
// Rev 1.0 - initial release
// ============================================================================
module sprite_layer_mixer #(
  parameter int         FLASH_FRAMES = 8,
  parameter logic [7:0] FLASH_BOOST  = 8'h40,
  parameter int         H_ACTIVE     = 640,
  parameter int         V_ACTIVE     = 480
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       is_score,
  input  logic [7:0] score_data,
  input  logic       is_gem,
  input  logic [7:0] gem_data,
  input  logic       is_player1,
  input  logic       is_player2,
  input  logic [7:0] player1_data,
  input  logic [7:0] player2_data,
  input  logic [7:0] bg_data,
  input  logic [3:0] score_hex,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int              CW           = $clog2(FLASH_FRAMES + 1);
  localparam logic [CW-1:0]   c_flash_load = CW'(FLASH_FRAMES);
  localparam logic [CW-1:0]   c_cnt_one    = CW'(1);
  localparam logic [10:0]     c_h_active   = 11'(H_ACTIVE);
  localparam logic [10:0]     c_v_active   = 11'(V_ACTIVE);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLASH = 1'b1
  } state_t;

  // Stage-1 registers
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_is_score;
  logic       r_is_p1;
  logic       r_is_p2;
  logic       r_is_gem;
  logic [7:0] r_score_data;
  logic [7:0] r_p1_data;
  logic [7:0] r_p2_data;
  logic [7:0] r_bg_data;
  logic       r_prev_origin;

  logic [3:0]    r_score_q;
  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_flash_cnt;
  logic [CW-1:0] w_cnt_nx;

  logic [7:0]  w_idx;
  logic [23:0] w_pal;
  logic        w_blank;
  logic        w_at_origin;
  logic        w_frame_start;
  logic        w_inc;
  logic        w_dec;

  function automatic logic [7:0] f_boost(input logic [7:0] c);
    logic [8:0] s;
    s = {1'b0, c} + {1'b0, FLASH_BOOST};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_is_score    <= 1'b0;
      r_is_p1       <= 1'b0;
      r_is_p2       <= 1'b0;
      r_is_gem      <= 1'b0;
      r_score_data  <= '0;
      r_p1_data     <= '0;
      r_p2_data     <= '0;
      r_bg_data     <= '0;
      r_prev_origin <= 1'b0;
      r_score_q     <= '0;
    end else begin
      r_x           <= DrawX;
      r_y           <= DrawY;
      r_is_score    <= is_score;
      r_is_p1       <= is_player1;
      r_is_p2       <= is_player2;
      r_is_gem      <= is_gem;
      r_score_data  <= score_data;
      r_p1_data     <= player1_data;
      r_p2_data     <= player2_data;
      r_bg_data     <= bg_data;
      r_prev_origin <= w_at_origin;
      r_score_q     <= score_hex;
    end
  end

  // gem_data arrives one cycle late, so it is used live against stage-1 flags.
  always_comb begin
    w_idx = r_bg_data;
    if (r_is_score && (r_score_data != 8'h00)) begin
      w_idx = r_score_data;
    end else if (r_is_p1 && (r_p1_data != 8'h00)) begin
      w_idx = r_p1_data;
    end else if (r_is_p2 && (r_p2_data != 8'h00)) begin
      w_idx = r_p2_data;
    end else if (r_is_gem && (gem_data != 8'h00)) begin
      w_idx = gem_data;
    end
  end

  // Team palette; the upper nibble of the index is don't-care.
  always_comb begin
    w_pal = 24'h000000;
    casez (w_idx)
      8'b????_0000: w_pal = 24'h000000;
      8'b????_0001: w_pal = 24'h0000AA;
      8'b????_0010: w_pal = 24'h00AA00;
      8'b????_0011: w_pal = 24'h00AAAA;
      8'b????_0100: w_pal = 24'hAA0000;
      8'b????_0101: w_pal = 24'hAA00AA;
      8'b????_0110: w_pal = 24'hAA5500;
      8'b????_0111: w_pal = 24'hAAAAAA;
      8'b????_1000: w_pal = 24'hFFFFFF;
      8'b????_1001: w_pal = 24'h5555FF;
      8'b????_1010: w_pal = 24'h55FF55;
      8'b????_1011: w_pal = 24'h55FFFF;
      8'b????_1100: w_pal = 24'hFF5555;
      8'b????_1101: w_pal = 24'hFF55FF;
      8'b????_1110: w_pal = 24'hFFFF55;
      8'b????_1111: w_pal = 24'h555555;
      default:      w_pal = 24'h000000;
    endcase
  end

  assign w_blank       = ({1'b0, r_x} >= c_h_active) || ({1'b0, r_y} >= c_v_active);
  assign w_at_origin   = (r_x == 10'd0) && (r_y == 10'd0);
  assign w_frame_start = w_at_origin && !r_prev_origin;
  assign w_inc         = (score_hex > r_score_q);
  assign w_dec         = (score_hex < r_score_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_flash_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_flash_cnt <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_flash_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_inc) begin
          w_state_nx = ST_FLASH;
          w_cnt_nx   = c_flash_load;
        end
      end
      ST_FLASH: begin
        // A score drop cancels; a new pickup restarts the count before any frame tick.
        if (w_dec) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end else if (w_inc) begin
          w_cnt_nx   = c_flash_load;
        end else if (w_frame_start) begin
          if (r_flash_cnt == c_cnt_one) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx   = r_flash_cnt - c_cnt_one;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Stage 2: boost uses the state current at the colour-register edge.
  always_ff @(posedge Clk) begin
    if (Reset || w_blank) begin
      VGA_R <= 8'h00;
      VGA_G <= 8'h00;
      VGA_B <= 8'h00;
    end else if (r_state == ST_FLASH) begin
      VGA_R <= f_boost(w_pal[23:16]);
      VGA_G <= f_boost(w_pal[15:8]);
      VGA_B <= f_boost(w_pal[7:0]);
    end else begin
      VGA_R <= w_pal[23:16];
      VGA_G <= w_pal[15:8];
      VGA_B <= w_pal[7:0];
    end
  end

endmodule
`default_nettype wire
